// File: rtl/camera_line_fifo_if.sv
// ----------------------------------------------------------------------------
// camera_line_fifo_if
// Bundles the pixel write port, the Avalon-MM slave port and the capture-loop
// status lines of camera_line_fifo.
//   wr_en / wr_data        : pixel words from the camera interface
//   avs_address/read/write : Avalon-MM register access (read latency 1)
//   avs_writedata          : Avalon write data
//   avs_readdata           : Avalon read data
//   shutter                : capture request back to the camera interface
//   empty / full           : registered FIFO occupancy flags
// Modports: slave = the FIFO itself, master = whoever drives it.
// ----------------------------------------------------------------------------
interface camera_line_fifo_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        shutter;
    logic        empty;
    logic        full;

    modport slave (
        input  wr_en, wr_data, avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, shutter, empty, full
    );

    modport master (
        output wr_en, wr_data, avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, shutter, empty, full
    );
endinterface

// File: rtl/camera_line_fifo.sv
// ----------------------------------------------------------------------------
// camera_line_fifo
// Capture buffer behind the camera interface: stores pixel words in a
// DEPTH x 32 FIFO, exposes them to the HPS through four Avalon registers
// (0 DATA pop, 1 STATUS, 2 CONTROL, 3 TOTAL) and generates the shutter pulse.
// Ports:
//   clk   : sole clock
//   reset : asynchronous, active-high, clears all state
//   bus   : camera_line_fifo_if.slave (pixel write, Avalon slave, flags)
// ----------------------------------------------------------------------------
module camera_line_fifo #(
    parameter int DEPTH          = 512,
    parameter int AW             = 9,
    parameter int SHUTTER_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    camera_line_fifo_if.slave   bus
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [7:0]  SHUT_LOAD = 8'(SHUTTER_CYCLES - 1);
    localparam logic [31:0] LINE_WORDS = 32'd320;

    typedef enum logic {S_IDLE, S_PULSE} shut_state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [31:0]   r_total;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_line_done;
    logic          r_empty;
    logic          r_full;
    logic [31:0]   r_readdata;
    shut_state_t   r_state;
    shut_state_t   w_state_next;
    logic [7:0]    r_shut_cnt;
    logic          w_shutter;

    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_trigger;
    logic          w_data_rd;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_cnt_next;
    logic [31:0]   w_total_next;
    logic [31:0]   w_status;

    // Flush outranks both the pixel write and a DATA pop in the same cycle.
    assign w_ctrl_wr = bus.avs_write && (bus.avs_address == 2'd2);
    assign w_flush   = w_ctrl_wr && bus.avs_writedata[1];
    assign w_trigger = w_ctrl_wr && bus.avs_writedata[0];
    assign w_data_rd = bus.avs_read && (bus.avs_address == 2'd0);
    assign w_push    = bus.wr_en && (r_cnt != FULL_CNT) && !w_flush;
    assign w_pop     = w_data_rd && (r_cnt != '0) && !w_flush;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_flush)
            w_cnt_next = '0;
        else if (w_push && !w_pop)
            w_cnt_next = r_cnt + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_next = r_cnt - 1'b1;
    end

    // Saturating word counter.
    assign w_total_next = (w_push && (r_total != '1)) ? r_total + 1'b1 : r_total;

    assign w_status = {{(15-AW){1'b0}}, r_cnt, 11'b0,
                       r_line_done, r_underflow, r_overflow, r_full, r_empty};

    // NOTE: the storage array has no reset; clearing it would turn the RAM into
    // flops, and the pointers/cnt already make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= bus.wr_data;
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_total     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_line_done <= 1'b0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_readdata  <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_empty <= (w_cnt_next == '0);
            r_full  <= (w_cnt_next == FULL_CNT);

            if (w_flush) begin
                r_wp        <= '0;
                r_rp        <= '0;
                r_total     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
                r_line_done <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wp    <= r_wp + 1'b1;
                    r_total <= w_total_next;
                    if (w_total_next >= LINE_WORDS)
                        r_line_done <= 1'b1;
                end
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                // A full FIFO drops the word even if a pop frees a slot this cycle.
                if (bus.wr_en && (r_cnt == FULL_CNT))
                    r_overflow <= 1'b1;
                if (w_data_rd && (r_cnt == '0))
                    r_underflow <= 1'b1;
            end

            // Read data is held between reads.
            if (bus.avs_read) begin
                case (bus.avs_address)
                    2'd0:    r_readdata <= w_pop ? r_mem[r_rp] : '0;
                    2'd1:    r_readdata <= w_status;
                    2'd3:    r_readdata <= r_total;
                    default: r_readdata <= '0;
                endcase
            end
        end
    end

    // Shutter FSM: state register plus pulse down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shut_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_trigger)
                r_shut_cnt <= SHUT_LOAD;
            else if ((r_state == S_PULSE) && (r_shut_cnt != '0))
                r_shut_cnt <= r_shut_cnt - 1'b1;
        end
    end

    // Shutter FSM: next state. A retrigger reloads the counter and stays in PULSE.
    always_comb begin
        w_state_next = r_state;
        if (w_trigger)
            w_state_next = S_PULSE;
        else if ((r_state == S_PULSE) && (r_shut_cnt == '0))
            w_state_next = S_IDLE;
    end

    // Shutter FSM: output decoded from the state flop so reset drops it at once.
    always_comb begin
        w_shutter = 1'b0;
        if (r_state == S_PULSE)
            w_shutter = 1'b1;
    end

    assign bus.avs_readdata = r_readdata;
    assign bus.shutter      = w_shutter;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;

endmodule

// File: tb/tb_camera_line_fifo.sv
module tb_camera_line_fifo;

    localparam int DEPTH = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    camera_line_fifo_if bus ();

    camera_line_fifo #(
        .DEPTH          (DEPTH),
        .AW             (9),
        .SHUTTER_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        bus.avs_read    = 1'b1;
        bus.avs_address = a;
        tick();
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_write     = 1'b1;
        bus.avs_address   = a;
        bus.avs_writedata = d;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    // Counts shutter-high samples after a trigger, optionally retriggering
    // after sample index retrig_at; bounded to 60 samples.
    task automatic shutter_run(input int retrig_at, output int n);
        avs_wr(2'd2, 32'h1);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.shutter) n++;
            bus.avs_write     = (c == retrig_at);
            bus.avs_address   = 2'd2;
            bus.avs_writedata = 32'h1;
            tick();
        end
        bus.avs_write = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] q[$];
    logic [31:0] exp_word;
    int          n;

    initial begin
        bus.wr_en = 0; bus.wr_data = '0; bus.avs_address = '0;
        bus.avs_read = 0; bus.avs_write = 0; bus.avs_writedata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_shutter", 32'(bus.shutter), 32'd0);
        check("rst_readdata", bus.avs_readdata, 32'd0);
        reset = 1'b0;

        // Four words in, four back-to-back DATA reads out
        push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333); push(32'h4444_4444);
        check("four_empty", 32'(bus.empty), 32'd0);
        avs_rd(2'd1, rd); check("four_status", rd, 32'h0004_0000);
        bus.avs_read = 1'b1; bus.avs_address = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_word = 32'h1111_1111 * i;
            check("four_data", bus.avs_readdata, exp_word);
        end
        bus.avs_read = 1'b0;
        avs_rd(2'd1, rd); check("four_status_end", rd, 32'h0000_0001);
        avs_rd(2'd3, rd); check("four_total", rd, 32'd4);
        avs_wr(2'd1, 32'hFFFF_FFFF); avs_wr(2'd3, 32'h2); avs_wr(2'd0, 32'h2);
        avs_rd(2'd3, rd); check("ignored_writes", rd, 32'd4);
        avs_rd(2'd2, rd); check("control_read", rd, 32'd0);

        // Fill to DEPTH, then an overflowing word
        avs_wr(2'd2, 32'h2);
        for (int i = 0; i < DEPTH; i++) push(32'hA000_0000 | 32'(i));
        check("fill_full", 32'(bus.full), 32'd1);
        avs_rd(2'd1, rd); check("fill_status", rd, 32'h0200_0012);
        push(32'hDEAD_BEEF);
        avs_rd(2'd1, rd); check("ovf_status", rd, 32'h0200_0016);
        avs_rd(2'd3, rd); check("ovf_total", rd, 32'd512);
        bus.avs_read = 1'b1; bus.avs_address = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("drain_data", bus.avs_readdata, 32'hA000_0000 | 32'(i));
        end
        bus.avs_read = 1'b0;

        // Underflow, then flush
        avs_rd(2'd0, rd); check("udf_data", rd, 32'd0);
        avs_rd(2'd1, rd); check("udf_status", rd, 32'h0000_001D);
        avs_wr(2'd2, 32'h2);
        avs_rd(2'd1, rd); check("flush_status", rd, 32'h0000_0001);
        avs_rd(2'd3, rd); check("flush_total", rd, 32'd0);

        // Concurrent write and pop at occupancy 5
        for (int i = 0; i < 5; i++) begin
            push(32'h5000_0000 | 32'(i));
            q.push_back(32'h5000_0000 | 32'(i));
        end
        for (int c = 0; c < 100; c++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'h6000_0000 | 32'(c);
            bus.avs_read = 1'b1; bus.avs_address = 2'd0;
            q.push_back(bus.wr_data);
            exp_word = q.pop_front();
            tick();
            check("conc_data", bus.avs_readdata, exp_word);
        end
        bus.wr_en = 1'b0; bus.avs_read = 1'b0;
        avs_rd(2'd1, rd); check("conc_status", rd, 32'h0005_0000);
        avs_rd(2'd3, rd); check("conc_total", rd, 32'd105);

        // Flush beats a same-cycle pixel write
        bus.wr_en = 1'b1; bus.wr_data = 32'h7777_7777;
        avs_wr(2'd2, 32'h2);
        bus.wr_en = 1'b0;
        avs_rd(2'd1, rd); check("flush_vs_wr_status", rd, 32'h0000_0001);
        avs_rd(2'd3, rd); check("flush_vs_wr_total", rd, 32'd0);

        // line_done threshold
        for (int i = 0; i < 319; i++) push(32'(i));
        avs_rd(2'd1, rd); check("line_319", rd, 32'h013F_0000);
        push(32'd319);
        avs_rd(2'd1, rd); check("line_320", rd, 32'h0140_0010);
        avs_wr(2'd2, 32'h2);

        // Shutter pulse length, retrigger, flush during pulse
        shutter_run(-1, n); check("shutter_len", 32'(n), 32'd16);
        shutter_run(9, n);  check("shutter_retrig", 32'(n), 32'd26);
        avs_wr(2'd2, 32'h1);
        avs_wr(2'd2, 32'h2);
        check("shutter_flush", 32'(bus.shutter), 32'd1);
        repeat (20) tick();
        check("shutter_done", 32'(bus.shutter), 32'd0);

        // Reset mid-pulse with data stored
        push(32'hAAAA_0001); push(32'hAAAA_0002);
        avs_wr(2'd2, 32'h1);
        repeat (4) tick();
        check("pre_rst_shutter", 32'(bus.shutter), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_shutter", 32'(bus.shutter), 32'd0);
        check("async_rst_empty", 32'(bus.empty), 32'd1);
        @(negedge clk) reset = 1'b0;
        avs_rd(2'd1, rd); check("post_rst_status", rd, 32'h0000_0001);
        avs_rd(2'd3, rd); check("post_rst_total", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/camera_line_fifo.md
# camera_line_fifo

Single-clock capture buffer directly downstream of the camera interface. Accepts the 32-bit pixel words and write strobes that stage produces, stores one captured line (or more) in an on-chip FIFO, and exposes it to the HPS through an Avalon-MM slave. Also produces the active-high shutter pulse and the `empty` flag that the camera interface consumes, closing the capture loop under software control.

## Interface
- `DEPTH`, 512 — FIFO depth in 32-bit words; power of two, ≥ 4.
- `AW`, 9 — pointer width, log2(DEPTH).
- `SHUTTER_CYCLES`, 16 — shutter pulse length in clk cycles, 1..255.
- `clk`  in  1  — sole clock (camera pixel clock domain).
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `wr_en`  in  1  — write strobe from camera interface; one word per high cycle.
- `wr_data`  in  32  — pixel word, sampled on posedge `clk` when `wr_en`=1.
- `avs_address`  in  2  — register select.
- `avs_read`  in  1  — Avalon read strobe.
- `avs_write`  in  1  — Avalon write strobe.
- `avs_writedata`  in  32  — write data.
- `avs_readdata`  out  32  — read data, fixed read latency 1.
- `shutter`  out  1  — capture request to camera interface, active high.
- `empty`  out  1  — FIFO occupancy is zero (registered).
- `full`  out  1  — FIFO occupancy equals DEPTH (registered).

## Operation
- Storage: DEPTH×32 RAM, write pointer `wp`, read pointer `rp` (AW bits, wrap modulo DEPTH), occupancy `cnt` (AW+1 bits, 0..DEPTH).
- Register map (word addresses):
  - 0 DATA (R): returns head word and pops it. Read when empty: returns 0, no pop, sets `underflow`.
  - 1 STATUS (R): [0] empty, [1] full, [2] overflow, [3] underflow, [4] line_done, [15:5] 0, [16+AW:16] `cnt`, rest 0.
  - 2 CONTROL (W): bit0=1 → start shutter pulse; bit1=1 → flush (pointers, `cnt`, `total`, all sticky flags to 0). Reads return 0.
  - 3 TOTAL (R): words accepted since reset/flush, 32-bit, saturates at 0xFFFF_FFFF.
- Write path: `wr_en` with `cnt`<DEPTH (pre-edge value) → store at `wp`, `wp`+1, `total`+1. `wr_en` with `cnt`=DEPTH → word dropped, `overflow` set; simultaneous pop does not rescue it.
- Simultaneous accepted write and pop: both happen, `cnt` unchanged.
- `line_done` sticky: set when `total` becomes ≥ 320 (one 640-pixel RGB565 line); cleared only by flush/reset.
- Flush wins over a same-cycle `wr_en` (word dropped, no flag) and over a same-cycle DATA read (returns 0, no underflow).
- Writes to addresses 0, 1, 3 are ignored. Reads of undefined bits return 0.
- Shutter FSM: IDLE → PULSE on CONTROL bit0 write; PULSE holds `shutter`=1 for exactly SHUTTER_CYCLES cycles via down-counter, then IDLE. Trigger during PULSE reloads the counter (pulse extended). Flush does not affect the shutter FSM.

## Timing
- Reset values: `avs_readdata`=0, `shutter`=0, `empty`=1, `full`=0, pointers/`cnt`/`total`/flags=0, FSM=IDLE.
- `reset` asserted mid-capture or mid-pulse: immediate clear; stored data discarded; `shutter` drops asynchronously.
- Read latency 1: `avs_read` sampled at edge N → `avs_readdata` valid after edge N, held until next read. Pop takes effect at edge N; back-to-back reads return consecutive words.
- `wr_data` written at edge N is readable by a DATA read issued at edge N+1 or later; `empty` deasserts after edge N.
- `empty`/`full`/STATUS reflect state after the previous edge.
- `shutter` rises one cycle after the CONTROL write edge.
- No wait-request; every access completes in one cycle.

## Test plan
- Reset then write 4 words 0x11111111..0x44444444 → STATUS=0x0004_0000, `empty`=0; four DATA reads return them in order, final STATUS empty=1, TOTAL=4.
- Fill DEPTH words, extra `wr_en` with 0xDEADBEEF → `full`=1, overflow=1, 0xDEADBEEF never read back, TOTAL=DEPTH.
- Concurrent `wr_en` and DATA read for 100 cycles at `cnt`=5 → `cnt` stays 5, output sequence matches input order.
- DATA read when empty → readdata 0, underflow=1; CONTROL write 0x2 → STATUS=0x0000_0001, TOTAL=0.
- Write 320 words → line_done=1 exactly after the 320th accepted word, not before.
- CONTROL write 0x1 → `shutter` high 16 cycles; retrigger at cycle 10 → high 26 cycles total; `reset` at cycle 5 → `shutter`=0 immediately.
